// File: rtl/a_close_to_b_driver_if.sv
// a_close_to_b_driver_if: operand input stream and result output stream of the driver.
// The master modport is the producer/consumer side; the slave modport is the driver.
interface a_close_to_b_driver_if;
    logic        In_Valid;
    logic        In_Ready;
    logic [11:0] In_A;
    logic [11:0] In_B;
    logic        Res_Valid;
    logic        Res_Ready;
    logic [11:0] Res_A;
    logic        Res_Flag;
    logic        Res_Err;
    modport master (output In_Valid, In_A, In_B, Res_Ready,
                    input  In_Ready, Res_Valid, Res_A, Res_Flag, Res_Err);
    modport slave  (input  In_Valid, In_A, In_B, Res_Ready,
                    output In_Ready, Res_Valid, Res_A, Res_Flag, Res_Err);
endinterface

// File: rtl/a_close_to_b_driver.sv
// a_close_to_b_driver: 2-deep operand FIFO, Start/Ack sequencer and result collector for the core.
// Optional macro DRV_SKIP_INVALID_EN rejects pairs with A >= B without running the core.
module a_close_to_b_driver (
    input  logic                          Clk,
    input  logic                          Reset,
    a_close_to_b_driver_if.slave          s,
    output logic [11:0]                   Ain,
    output logic [11:0]                   Bin,
    output logic                          Start,
    output logic                          Ack,
    input  logic                          Qi,
    input  logic                          Qc,
    input  logic                          Qd,
    input  logic [11:0]                   A,
    input  logic                          Flag,
    output logic [7:0]                    Pair_Count
);
`ifdef DRV_SKIP_INVALID_EN
    localparam logic SKIP_EN = 1'b1;
`else
    localparam logic SKIP_EN = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, START, WAIT, RESP, ACK} state_t;
    state_t      state_q, state_d;
    logic [11:0] fa_q [2];
    logic [11:0] fb_q [2];
    logic [11:0] fa_d [2];
    logic [11:0] fb_d [2];
    logic        rd_q, rd_d, wr_q, wr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [11:0] ain_q, ain_d, bin_q, bin_d, res_a_q, res_a_d;
    logic        res_flag_q, res_flag_d, res_err_q, res_err_d;
    logic [7:0]  pc_q, pc_d;
    logic        push, pop, skip;
    logic        unused_qc;
    assign unused_qc = Qc;
    always_comb begin
        state_d    = state_q;
        fa_d       = fa_q;
        fb_d       = fb_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        ain_d      = ain_q;
        bin_d      = bin_q;
        res_a_d    = res_a_q;
        res_flag_d = res_flag_q;
        res_err_d  = res_err_q;
        pc_d       = pc_q;
        pop        = 1'b0;
        // a full FIFO refuses a push even if a pop happens in the same cycle
        push       = s.In_Valid && cnt_q != 2'd2;
        skip       = SKIP_EN && fa_q[rd_q] >= fb_q[rd_q];
        if (push) begin
            fa_d[wr_q] = s.In_A;
            fb_d[wr_q] = s.In_B;
            wr_d       = ~wr_q;
        end
        case (state_q)
            IDLE: if (cnt_q != 2'd0 && Qi) begin
                pop  = 1'b1;
                rd_d = ~rd_q;
                if (skip) begin
                    res_a_d    = fa_q[rd_q];
                    res_flag_d = 1'b0;
                    res_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    ain_d   = fa_q[rd_q];
                    bin_d   = fb_q[rd_q];
                    state_d = START;
                end
            end
            START: state_d = WAIT;
            WAIT: if (Qd) begin
                res_a_d    = A;
                res_flag_d = Flag;
                res_err_d  = 1'b0;
                state_d    = RESP;
            end
            RESP: if (s.Res_Ready) begin
                pc_d    = pc_q + 8'd1;
                state_d = res_err_q ? IDLE : ACK;
            end
            ACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
    always_ff @(posedge Clk) begin
        fa_q <= fa_d;
        fb_q <= fb_d;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            cnt_q      <= 2'd0;
            ain_q      <= 12'd0;
            bin_q      <= 12'd0;
            res_a_q    <= 12'd0;
            res_flag_q <= 1'b0;
            res_err_q  <= 1'b0;
            pc_q       <= 8'd0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            ain_q      <= ain_d;
            bin_q      <= bin_d;
            res_a_q    <= res_a_d;
            res_flag_q <= res_flag_d;
            res_err_q  <= res_err_d;
            pc_q       <= pc_d;
        end
    end
    assign s.In_Ready  = cnt_q != 2'd2;
    assign s.Res_Valid = state_q == RESP;
    assign s.Res_A     = res_a_q;
    assign s.Res_Flag  = res_flag_q;
    assign s.Res_Err   = res_err_q;
    assign Start       = state_q == START;
    assign Ack         = state_q == ACK;
    assign Ain         = ain_q;
    assign Bin         = bin_q;
    assign Pair_Count  = pc_q;
endmodule
